// File: rtl/demux_if.sv
// Producer/consumer bundle for the 1-to-16 lane demux.
// slave = the demux itself, master = the producer/consumer side.
interface demux_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic [3:0]       select;
   logic [WIDTH-1:0] o0;
   logic [WIDTH-1:0] o1;
   logic [WIDTH-1:0] o2;
   logic [WIDTH-1:0] o3;
   logic [WIDTH-1:0] o4;
   logic [WIDTH-1:0] o5;
   logic [WIDTH-1:0] o6;
   logic [WIDTH-1:0] o7;
   logic [WIDTH-1:0] o8;
   logic [WIDTH-1:0] o9;
   logic [WIDTH-1:0] o10;
   logic [WIDTH-1:0] o11;
   logic [WIDTH-1:0] o12;
   logic [WIDTH-1:0] o13;
   logic [WIDTH-1:0] o14;
   logic [WIDTH-1:0] o15;
   logic [15:0]      o_valid;
   logic [15:0]      o_ack;
   logic [7:0]       stall_cnt;

   modport master (
      output in_valid, din, select, o_ack,
      input  in_ready, o_valid, stall_cnt,
      input  o0, o1, o2, o3, o4, o5, o6, o7,
      input  o8, o9, o10, o11, o12, o13, o14, o15
   );

   modport slave (
      input  in_valid, din, select, o_ack,
      output in_ready, o_valid, stall_cnt,
      output o0, o1, o2, o3, o4, o5, o6, o7,
      output o8, o9, o10, o11, o12, o13, o14, o15
   );
endinterface

// File: rtl/demux.sv
// Registered 1-to-16 demux with per-lane valid/ack holding registers
// and a saturating stall counter for back-pressure observation.
module demux #(
   parameter int WIDTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   demux_if.slave bus
);
   logic [WIDTH-1:0] data_q [16];
   logic [WIDTH-1:0] data_d [16];
   logic [15:0]      valid_q;
   logic [15:0]      valid_d;
   logic [7:0]       cnt_q;
   logic [7:0]       cnt_d;
   logic             ready;
   logic             accept;
   logic             stall;

   // Lane can take a word if empty or being drained this cycle.
   always_comb begin
      ready  = ~valid_q[bus.select] | bus.o_ack[bus.select];
      accept = bus.in_valid & ready;
      stall  = bus.in_valid & ~ready;
   end

   // Next state: acks clear, an accept re-sets its lane on top.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q & ~bus.o_ack;
      cnt_d   = cnt_q;
      if (accept) begin
         data_d[bus.select]  = bus.din;
         valid_d[bus.select] = 1'b1;
      end
      if (stall && cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) begin
            data_q[k] <= '0;
         end
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.o_valid   = valid_q;
   assign bus.stall_cnt = cnt_q;
   assign bus.o0  = data_q[0];
   assign bus.o1  = data_q[1];
   assign bus.o2  = data_q[2];
   assign bus.o3  = data_q[3];
   assign bus.o4  = data_q[4];
   assign bus.o5  = data_q[5];
   assign bus.o6  = data_q[6];
   assign bus.o7  = data_q[7];
   assign bus.o8  = data_q[8];
   assign bus.o9  = data_q[9];
   assign bus.o10 = data_q[10];
   assign bus.o11 = data_q[11];
   assign bus.o12 = data_q[12];
   assign bus.o13 = data_q[13];
   assign bus.o14 = data_q[14];
   assign bus.o15 = data_q[15];
endmodule

// File: tb/tb_demux.sv
// Bench for demux: directed vectors, a lane-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_demux;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   demux_if #(.WIDTH(4)) bus ();

   demux #(.WIDTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [3:0] dut_o [16];
   assign dut_o[0]  = bus.o0;
   assign dut_o[1]  = bus.o1;
   assign dut_o[2]  = bus.o2;
   assign dut_o[3]  = bus.o3;
   assign dut_o[4]  = bus.o4;
   assign dut_o[5]  = bus.o5;
   assign dut_o[6]  = bus.o6;
   assign dut_o[7]  = bus.o7;
   assign dut_o[8]  = bus.o8;
   assign dut_o[9]  = bus.o9;
   assign dut_o[10] = bus.o10;
   assign dut_o[11] = bus.o11;
   assign dut_o[12] = bus.o12;
   assign dut_o[13] = bus.o13;
   assign dut_o[14] = bus.o14;
   assign dut_o[15] = bus.o15;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: each lane is a one-deep mailbox.
   logic [3:0] m_data [16];
   bit         m_full [16];
   int         m_stalls;

   function automatic bit m_ready();
      return !m_full[bus.select] || bus.o_ack[bus.select];
   endfunction

   function automatic logic [15:0] m_valid_vec();
      logic [15:0] v = '0;
      for (int k = 0; k < 16; k++) v[k] = m_full[k];
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) begin
            m_data[k] <= 4'h0;
            m_full[k] <= 1'b0;
         end
         m_stalls <= 0;
      end else begin
         for (int k = 0; k < 16; k++) begin
            if (bus.in_valid && m_ready() && int'(bus.select) == k) begin
               m_data[k] <= bus.din;
               m_full[k] <= 1'b1;
            end else if (bus.o_ack[k]) begin
               m_full[k] <= 1'b0;
            end
         end
         if (bus.in_valid && !m_ready())
            m_stalls <= (m_stalls < 255) ? m_stalls + 1 : 255;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("in_ready", 32'(bus.in_ready), 32'(m_ready()));
      check("o_valid", 32'(bus.o_valid), 32'(m_valid_vec()));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stalls));
      for (int k = 0; k < 16; k++)
         check($sformatf("lane%0d", k), 32'(dut_o[k]), 32'(m_data[k]));
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.din      = 4'h0;
      bus.select   = 4'h0;
      bus.o_ack    = 16'h0;
      tick(2);
      rst = 1'b0;
      check("rst_valid", 32'(bus.o_valid), 32'h0);
      check("rst_cnt", 32'(bus.stall_cnt), 32'h0);

      for (int k = 0; k < 16; k++) begin
         bus.in_valid = 1'b1;
         bus.select   = 4'(k);
         bus.din      = 4'(k);
         tick();
      end
      bus.in_valid = 1'b0;
      check("sweep_valid", 32'(bus.o_valid), 32'hFFFF);
      check("sweep_o5", 32'(bus.o5), 32'h5);
      check("sweep_o15", 32'(bus.o15), 32'hF);

      bus.in_valid = 1'b1;
      bus.select   = 4'd5;
      bus.din      = 4'hA;
      #1;
      check("full_ready", 32'(bus.in_ready), 32'h0);
      tick(10);
      check("bp_cnt", 32'(bus.stall_cnt), 32'd10);
      check("bp_o5", 32'(bus.o5), 32'h5);
      bus.o_ack = 16'h0020;
      #1;
      check("ack_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.o_ack    = 16'h0;
      bus.in_valid = 1'b0;
      check("ackw_o5", 32'(bus.o5), 32'hA);
      check("ackw_v5", 32'(bus.o_valid[5]), 32'h1);
      check("ackw_cnt", 32'(bus.stall_cnt), 32'd10);

      bus.o_ack    = 16'h0004;
      bus.in_valid = 1'b1;
      bus.select   = 4'd2;
      bus.din      = 4'h3;
      tick();
      check("sim_o2_pre", 32'(bus.o2), 32'h3);
      bus.din = 4'hC;
      tick();
      bus.o_ack    = 16'h0;
      bus.in_valid = 1'b0;
      check("sim_o2", 32'(bus.o2), 32'hC);
      check("sim_v2", 32'(bus.o_valid[2]), 32'h1);
      check("sim_cnt", 32'(bus.stall_cnt), 32'd10);

      bus.o_ack = 16'h0080;
      tick();
      check("drain7", 32'(bus.o_valid), 32'hFF7F);
      tick();
      bus.o_ack = 16'h0;
      check("empty_ack", 32'(bus.o_valid), 32'hFF7F);
      check("empty_o7", 32'(bus.o7), 32'h7);

      bus.o_ack = 16'h8003;
      tick();
      bus.o_ack = 16'h0;
      check("multi_valid", 32'(bus.o_valid), 32'h7F7C);
      check("multi_o0", 32'(bus.o0), 32'h0);
      check("multi_o1", 32'(bus.o1), 32'h1);
      check("multi_o15", 32'(bus.o15), 32'hF);

      bus.in_valid = 1'b1;
      bus.select   = 4'd3;
      bus.din      = 4'h9;
      tick(300);
      check("sat_cnt", 32'(bus.stall_cnt), 32'd255);
      tick(5);
      check("sat_hold", 32'(bus.stall_cnt), 32'd255);
      check("sat_o3", 32'(bus.o3), 32'h3);

      #2;
      rst = 1'b1;
      #1;
      check("arst_o3", 32'(bus.o3), 32'h0);
      check("arst_o9", 32'(bus.o9), 32'h0);
      check("arst_valid", 32'(bus.o_valid), 32'h0);
      check("arst_cnt", 32'(bus.stall_cnt), 32'h0);
      check("arst_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1;
      bus.select = 4'd4;
      bus.din    = 4'h6;
      rst        = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      check("post_o4", 32'(bus.o4), 32'h6);
      check("post_valid", 32'(bus.o_valid), 32'h0010);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
